// File: rtl/hier_fanout_node.sv
// -----------------------------------------------------------------------------
// hier_fanout_node
//
// Purpose:
//   Reusable node for generated multi-level module trees. A request from the
//   parent is issued either to one child (unicast, selected by req_idx) or to
//   every child (broadcast). Child responses are merged back to the parent via
//   a round-robin arbiter into a registered output slot. The number of child
//   transactions that have been issued but not yet answered is capped at
//   MAX_OUT.
//
// Ports:
//   clk, rst_n                      rising-edge clock, async active-low reset
//   req_valid/req_ready             parent request handshake
//   req_bcast, req_idx, req_data    request mode, unicast target, payload
//   child_req_valid/child_req_ready per-child request handshake
//   child_req_data                  shared request payload (registered)
//   child_rsp_valid/child_rsp_ready per-child response handshake
//   child_rsp_data                  packed child payloads, child i at
//                                   [i*DATA_W +: DATA_W]
//   rsp_valid/rsp_ready             parent response handshake (registered)
//   rsp_data, rsp_idx               response payload and source child id
//   outstanding                     current outstanding child transactions
//   err_pulse                       one-cycle strobe: bad unicast index or
//                                   unsolicited child response
// -----------------------------------------------------------------------------
module hier_fanout_node #(
    parameter  int NUM_CHILDREN = 5,
    parameter  int DATA_W       = 32,
    parameter  int MAX_OUT      = 8,
    localparam int IDX_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1,
    localparam int CNT_W        = $clog2(MAX_OUT + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_bcast,
    input  logic [IDX_W-1:0]               req_idx,
    input  logic [DATA_W-1:0]              req_data,

    output logic [NUM_CHILDREN-1:0]        child_req_valid,
    input  logic [NUM_CHILDREN-1:0]        child_req_ready,
    output logic [DATA_W-1:0]              child_req_data,

    input  logic [NUM_CHILDREN-1:0]        child_rsp_valid,
    output logic [NUM_CHILDREN-1:0]        child_rsp_ready,
    input  logic [NUM_CHILDREN*DATA_W-1:0] child_rsp_data,

    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_W-1:0]              rsp_data,
    output logic [IDX_W-1:0]               rsp_idx,

    output logic [CNT_W-1:0]               outstanding,
    output logic                           err_pulse
);

    // One extra bit so that outstanding + NUM_CHILDREN never wraps.
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] NC_S  = SUM_W'(NUM_CHILDREN);
    localparam logic [SUM_W-1:0] MAX_S = SUM_W'(MAX_OUT);
    localparam logic [IDX_W:0]   NC_I  = (IDX_W + 1)'(NUM_CHILDREN);
    localparam logic [NUM_CHILDREN-1:0] ONE_HOT0 = {{(NUM_CHILDREN - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        UNI,
        BCAST
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [NUM_CHILDREN-1:0] pending;
    logic [NUM_CHILDREN-1:0] pending_nxt;
    logic [DATA_W-1:0]       req_data_q;

    logic                    req_hs;
    logic                    idx_ok;
    logic                    bad_req;
    logic [NUM_CHILDREN-1:0] req_hs_vec;
    logic [SUM_W-1:0]        inc;

    logic [IDX_W-1:0]        ptr;
    logic [IDX_W:0]          cand;
    logic [NUM_CHILDREN-1:0] grant;
    logic [IDX_W-1:0]        winner;
    logic                    found;
    logic                    slot_free;
    logic                    rsp_hs;
    logic [DATA_W-1:0]       sel_data;
    logic                    unsolicited;
    logic                    dec;
    logic [SUM_W-1:0]        cnt_nxt;

    // ---------------- Request side ----------------
    // A broadcast could add NUM_CHILDREN transactions, so admission always
    // reserves room for the worst case regardless of request type.
    assign req_ready  = (state == IDLE) && (({1'b0, outstanding} + NC_S) <= MAX_S);
    assign req_hs     = req_valid && req_ready;
    assign idx_ok     = ({1'b0, req_idx} < NC_I);
    assign bad_req    = req_hs && !req_bcast && !idx_ok;

    assign child_req_valid = pending;
    assign child_req_data  = req_data_q;
    assign req_hs_vec      = pending & child_req_ready;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                if (req_hs) begin
                    if (req_bcast) begin
                        state_nxt   = BCAST;
                        pending_nxt = '1;
                    end else if (idx_ok) begin
                        state_nxt   = UNI;
                        pending_nxt = ONE_HOT0 << req_idx;
                    end
                end
            end
            UNI, BCAST: begin
                pending_nxt = pending & ~req_hs_vec;
                if (pending_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                pending_nxt = '0;
            end
        endcase
    end

    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            inc = inc + SUM_W'(req_hs_vec[i]);
        end
    end

    // ---------------- Response arbiter ----------------
    // Walk the children starting at the pointer; cand is kept in range by a
    // single conditional subtract since ptr + k < 2*NUM_CHILDREN.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= NC_I) begin
                cand = cand - NC_I;
            end
            if (!found && child_rsp_valid[cand[IDX_W-1:0]]) begin
                found                    = 1'b1;
                winner                   = cand[IDX_W-1:0];
                grant[cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (grant[i]) begin
                sel_data = child_rsp_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign slot_free       = !rsp_valid || rsp_ready;
    assign rsp_hs          = slot_free && found;
    assign child_rsp_ready = slot_free ? grant : '0;

    // A response with nothing outstanding is still forwarded; only the
    // counter decrement is suppressed so it cannot underflow.
    assign unsolicited = rsp_hs && (outstanding == '0);
    assign dec         = rsp_hs && !unsolicited;
    assign cnt_nxt     = {1'b0, outstanding} + inc - SUM_W'(dec);

    // ---------------- State registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= '0;
            outstanding <= '0;
            err_pulse   <= 1'b0;
            ptr         <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_idx     <= '0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            outstanding <= cnt_nxt[CNT_W-1:0];
            err_pulse   <= bad_req || unsolicited;
            if (rsp_hs) begin
                rsp_valid <= 1'b1;
                rsp_data  <= sel_data;
                rsp_idx   <= winner;
                ptr       <= (winner == IDX_W'(NUM_CHILDREN - 1)) ? '0 : winner + IDX_W'(1);
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Payload register: only written on an accepted parent request, which
    // cannot happen while any child request is pending.
    always_ff @(posedge clk) begin
        if (req_hs) begin
            req_data_q <= req_data;
        end
    end

endmodule

// File: tb/tb_hier_fanout_node.sv
// -----------------------------------------------------------------------------
// tb_hier_fanout_node
//
// Directed bench for hier_fanout_node with NUM_CHILDREN=5, DATA_W=32,
// MAX_OUT=8. Inputs change 1 time unit after a rising edge; outputs are
// checked before the next rising edge.
// -----------------------------------------------------------------------------
module tb_hier_fanout_node;

    localparam int NC     = 5;
    localparam int DW     = 32;
    localparam int MO     = 8;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_bcast;
    logic [IDX_W-1:0]  req_idx;
    logic [DW-1:0]     req_data;
    logic [NC-1:0]     child_req_valid;
    logic [NC-1:0]     child_req_ready;
    logic [DW-1:0]     child_req_data;
    logic [NC-1:0]     child_rsp_valid;
    logic [NC-1:0]     child_rsp_ready;
    logic [NC*DW-1:0]  child_rsp_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic [IDX_W-1:0]  rsp_idx;
    logic [CNT_W-1:0]  outstanding;
    logic              err_pulse;

    int n_checks = 0;
    int n_errors = 0;

    hier_fanout_node #(
        .NUM_CHILDREN (NC),
        .DATA_W       (DW),
        .MAX_OUT      (MO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_bcast       (req_bcast),
        .req_idx         (req_idx),
        .req_data        (req_data),
        .child_req_valid (child_req_valid),
        .child_req_ready (child_req_ready),
        .child_req_data  (child_req_data),
        .child_rsp_valid (child_rsp_valid),
        .child_rsp_ready (child_rsp_ready),
        .child_rsp_data  (child_rsp_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_idx         (rsp_idx),
        .outstanding     (outstanding),
        .err_pulse       (err_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-written expected grant orders for the two response bursts.
    int order_a [5] = '{4, 0, 1, 2, 3};
    int order_b [5] = '{2, 3, 4, 0, 1};

    initial begin
        rst_n           = 1'b0;
        req_valid       = 1'b0;
        req_bcast       = 1'b0;
        req_idx         = '0;
        req_data        = '0;
        child_req_ready = '0;
        child_rsp_valid = '0;
        rsp_ready       = 1'b1;
        for (int i = 0; i < NC; i++) begin
            child_rsp_data[i*DW +: DW] = 32'hC000_0000 + i;
        end

        // Reset state
        #3;
        chk("rst_child_req_valid", 64'(child_req_valid), 64'h0);
        chk("rst_rsp_valid",       64'(rsp_valid),       64'h0);
        chk("rst_rsp_data",        64'(rsp_data),        64'h0);
        chk("rst_rsp_idx",         64'(rsp_idx),         64'h0);
        chk("rst_outstanding",     64'(outstanding),     64'h0);
        chk("rst_err_pulse",       64'(err_pulse),       64'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Unicast to child 3, child already ready
        req_valid       = 1'b1;
        req_bcast       = 1'b0;
        req_idx         = 3'd3;
        req_data        = 32'hA5A5_0003;
        child_req_ready = 5'b01000;
        #1;
        chk("uni_req_ready_pre", 64'(req_ready), 64'h1);
        step();
        req_valid = 1'b0;
        #1;
        chk("uni_child_valid",   64'(child_req_valid), 64'h08);
        chk("uni_child_data",    64'(child_req_data),  64'hA5A5_0003);
        chk("uni_req_ready_busy",64'(req_ready),       64'h0);
        step();
        chk("uni_child_valid_off", 64'(child_req_valid), 64'h0);
        chk("uni_outstanding",     64'(outstanding),     64'h1);
        chk("uni_req_ready_again", 64'(req_ready),       64'h1);
        child_req_ready = '0;

        // Child 3 answers the unicast: pointer moves to 4
        child_rsp_valid = 5'b01000;
        #1;
        chk("uni_rsp_ready", 64'(child_rsp_ready), 64'h08);
        step();
        child_rsp_valid = '0;
        chk("uni_rsp_valid", 64'(rsp_valid),   64'h1);
        chk("uni_rsp_idx",   64'(rsp_idx),     64'h3);
        chk("uni_rsp_data",  64'(rsp_data),    64'hC000_0003);
        chk("uni_rsp_out",   64'(outstanding), 64'h0);
        step();
        chk("uni_rsp_drop",  64'(rsp_valid),   64'h0);

        // Broadcast 0x1234, children accept on cycles 1,1,3,4,4
        req_valid = 1'b1;
        req_bcast = 1'b1;
        req_data  = 32'h0000_1234;
        step();
        req_valid       = 1'b0;
        req_bcast       = 1'b0;
        child_req_ready = 5'b00011;
        #1;
        chk("bc_mask_c1",  64'(child_req_valid), 64'h1F);
        chk("bc_data",     64'(child_req_data),  64'h1234);
        step();
        child_req_ready = 5'b00000;
        chk("bc_mask_c2",  64'(child_req_valid), 64'h1C);
        chk("bc_out_c2",   64'(outstanding),     64'h2);
        step();
        child_req_ready = 5'b00100;
        chk("bc_mask_c3",  64'(child_req_valid), 64'h1C);
        step();
        child_req_ready = 5'b11000;
        chk("bc_mask_c4",  64'(child_req_valid), 64'h18);
        chk("bc_out_c4",   64'(outstanding),     64'h3);
        step();
        child_req_ready = '0;
        chk("bc_mask_done", 64'(child_req_valid), 64'h0);
        chk("bc_out_done",  64'(outstanding),     64'h5);
        chk("bc_req_ready", 64'(req_ready),       64'h0);

        // All five respond together; pointer is 4 from the earlier response
        child_rsp_valid = 5'b11111;
        for (int k = 0; k < NC; k++) begin
            step();
            child_rsp_valid[order_a[k]] = 1'b0;
            chk("burst_a_valid", 64'(rsp_valid),   64'h1);
            chk("burst_a_idx",   64'(rsp_idx),     64'(order_a[k]));
            chk("burst_a_data",  64'(rsp_data),    64'h0000_0000_C000_0000 + 64'(order_a[k]));
            chk("burst_a_out",   64'(outstanding), 64'(4 - k));
        end
        step();
        chk("burst_a_drop", 64'(rsp_valid), 64'h0);

        // Unsolicited child 1 response at outstanding 0
        child_rsp_valid = 5'b00010;
        step();
        child_rsp_valid = '0;
        chk("unsol_idx",   64'(rsp_idx),     64'h1);
        chk("unsol_valid", 64'(rsp_valid),   64'h1);
        chk("unsol_err",   64'(err_pulse),   64'h1);
        chk("unsol_out",   64'(outstanding), 64'h0);
        step();
        chk("unsol_err_off", 64'(err_pulse), 64'h0);

        // Broadcast with all children ready at once
        req_valid       = 1'b1;
        req_bcast       = 1'b1;
        req_data        = 32'h0000_5678;
        child_req_ready = 5'b11111;
        step();
        req_valid = 1'b0;
        req_bcast = 1'b0;
        step();
        child_req_ready = '0;
        chk("bc2_mask_done", 64'(child_req_valid), 64'h0);
        chk("bc2_out",       64'(outstanding),     64'h5);

        // Repeat burst with pointer at 2
        child_rsp_valid = 5'b11111;
        for (int k = 0; k < NC; k++) begin
            step();
            child_rsp_valid[order_b[k]] = 1'b0;
            chk("burst_b_idx", 64'(rsp_idx),     64'(order_b[k]));
            chk("burst_b_out", 64'(outstanding), 64'(4 - k));
        end
        step();

        // Fill to 4 with unicasts to child 0
        for (int k = 0; k < 4; k++) begin
            req_valid       = 1'b1;
            req_idx         = 3'd0;
            req_data        = 32'h0000_0100 + k;
            child_req_ready = 5'b00001;
            #1;
            chk("fill_req_ready", 64'(req_ready), 64'h1);
            step();
            req_valid = 1'b0;
            step();
        end
        child_req_ready = '0;
        chk("fill_out",        64'(outstanding), 64'h4);
        chk("fill_req_ready0", 64'(req_ready),   64'h0);

        // Drain one to 3: admission reopens
        child_rsp_valid = 5'b00001;
        step();
        child_rsp_valid = 5'b00010;
        rsp_ready       = 1'b0;
        chk("drain_out",       64'(outstanding), 64'h3);
        chk("drain_req_ready", 64'(req_ready),   64'h1);
        #1;
        chk("stall_child_rsp_ready", 64'(child_rsp_ready), 64'h0);
        step();
        step();
        chk("stall_valid", 64'(rsp_valid),   64'h1);
        chk("stall_data",  64'(rsp_data),    64'hC000_0000);
        chk("stall_idx",   64'(rsp_idx),     64'h0);
        chk("stall_out",   64'(outstanding), 64'h3);
        rsp_ready = 1'b1;
        #1;
        chk("unstall_child_rsp_ready", 64'(child_rsp_ready), 64'h02);
        step();
        child_rsp_valid = '0;
        chk("unstall_idx",  64'(rsp_idx),     64'h1);
        chk("unstall_data", 64'(rsp_data),    64'hC000_0001);
        chk("unstall_out",  64'(outstanding), 64'h2);
        step();
        chk("unstall_drop", 64'(rsp_valid), 64'h0);

        // Unicast to out-of-range child 6
        req_valid = 1'b1;
        req_idx   = 3'd6;
        req_data  = 32'hBAD0_0006;
        step();
        req_valid = 1'b0;
        chk("badidx_child_valid", 64'(child_req_valid), 64'h0);
        chk("badidx_err",         64'(err_pulse),       64'h1);
        chk("badidx_out",         64'(outstanding),     64'h2);
        chk("badidx_req_ready",   64'(req_ready),       64'h1);
        step();
        chk("badidx_err_off", 64'(err_pulse), 64'h0);

        // Reset mid-broadcast with children 3 and 4 still pending
        req_valid = 1'b1;
        req_bcast = 1'b1;
        req_data  = 32'h0000_9ABC;
        step();
        req_valid       = 1'b0;
        req_bcast       = 1'b0;
        child_req_ready = 5'b00111;
        step();
        child_req_ready = '0;
        chk("mid_mask", 64'(child_req_valid), 64'h18);
        chk("mid_out",  64'(outstanding),     64'h5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_child_valid", 64'(child_req_valid), 64'h0);
        chk("async_out",         64'(outstanding),     64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        child_rsp_valid = 5'b01010;
        #1;
        chk("post_rst_grant", 64'(child_rsp_ready), 64'h02);
        step();
        child_rsp_valid = '0;
        chk("post_rst_idx", 64'(rsp_idx),   64'h1);
        chk("post_rst_err", 64'(err_pulse), 64'h1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
